// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between an
// instruction-fetch port and a data load/store port, one access per cycle.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_WIDTH-1:0] inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [NUM_BYTES-1:0]  data_wstrb,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_WIDTH-1:0] data_rdata,

    output logic                  ram_en,
    output logic [NUM_BYTES-1:0]  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    owner_e last_grant_q, last_grant_d;
    owner_e pend_owner_q, pend_owner_d;
    logic   pend_valid_q, pend_valid_d;

    logic grant_inst;
    logic grant_data;

    // Under contention the port that did not win most recently takes the slot.
    always_comb begin
        grant_inst = inst_req && (!data_req || (last_grant_q == OWNER_DATA));
        grant_data = data_req && (!inst_req || (last_grant_q == OWNER_INST));
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        ram_en       = grant_inst || grant_data;
        ram_we       = (grant_data && data_wr) ? data_wstrb : '0;
        ram_addr     = grant_inst ? inst_addr : data_addr;
        ram_wdata    = data_wdata;
    end

    always_comb begin
        pend_valid_d = grant_inst || grant_data;
        pend_owner_d = pend_owner_q;
        last_grant_d = last_grant_q;
        if (grant_data) begin
            pend_owner_d = OWNER_DATA;
            last_grant_d = OWNER_DATA;
        end else if (grant_inst) begin
            pend_owner_d = OWNER_INST;
            last_grant_d = OWNER_INST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid_q <= 1'b0;
            pend_owner_q <= OWNER_INST;
            last_grant_q <= OWNER_INST;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The RAM read data is steered to whichever port owns the response slot.
    always_comb begin
        inst_data_ok = pend_valid_q && (pend_owner_q == OWNER_INST);
        data_data_ok = pend_valid_q && (pend_owner_q == OWNER_DATA);
        inst_rdata   = inst_data_ok ? ram_rdata : '0;
        data_rdata   = data_data_ok ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: grants are checked as they are issued,
// responses are queued and matched by a separate monitor.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [NB-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          ram_en;
    logic [NB-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with registered read; contents loaded on the first edge.
    logic [DW-1:0] mem [0:255];
    logic          loaded = 1'b0;

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        case (a)
            'h00: init_val = 32'h0000_1000;
            'h01: init_val = 32'h0000_1001;
            'h02: init_val = 32'h0000_1002;
            'h03: init_val = 32'h0000_1003;
            'h10: init_val = 32'hDEAD_BEEF;
            'h20: init_val = 32'hAABB_CCDD;
            'h21: init_val = 32'h5566_7788;
            'h30: init_val = 32'hC0DE_0030;
            'h31: init_val = 32'hC0DE_0031;
            'h32: init_val = 32'hC0DE_0032;
            'h40: init_val = 32'h0BAD_F00D;
            'h50: init_val = 32'hDA7A_0050;
            'h51: init_val = 32'hDA7A_0051;
            'h52: init_val = 32'hDA7A_0052;
            default: init_val = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < NB; b++)
                if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    typedef struct {
        bit            is_data;
        bit            chk_val;
        logic [DW-1:0] val;
        int            due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every data_ok must match the oldest outstanding grant.
    always @(negedge clk) begin
        exp_t e;
        if (inst_data_ok || data_data_ok) begin
            chk("single data_ok", {31'b0, inst_data_ok && data_data_ok}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp owner", {31'b0, data_data_ok}, {31'b0, e.is_data});
                chk("resp cycle", cyc, e.due);
                if (e.is_data) begin
                    if (e.chk_val) chk("data_rdata", data_rdata, e.val);
                    chk("inst_rdata idle", inst_rdata, '0);
                end else begin
                    chk("inst_rdata", inst_rdata, e.val);
                    chk("data_rdata idle", data_rdata, '0);
                end
            end
        end
    end

    task automatic set_in(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                          input logic [NB-1:0] ds, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ds;
        data_addr  = da;
        data_wdata = dwd;
    endtask

    task automatic cycle(input string name, input bit ei, input bit ed,
                         input logic [DW-1:0] ev, input bit echk);
        exp_t e;
        @(negedge clk);
        chk({name, " inst_addr_ok"}, {31'b0, inst_addr_ok}, {31'b0, ei});
        chk({name, " data_addr_ok"}, {31'b0, data_addr_ok}, {31'b0, ed});
        if (ei || ed) begin
            e.is_data = ed;
            e.chk_val = echk;
            e.val     = ev;
            e.due     = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        set_in(1'b1, 16'h10, 1'b1, 1'b0, '0, 16'h40, '0);
        repeat (3) begin
            @(negedge clk);
            chk("reset data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle("post-reset D", 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);

        set_in(1'b1, 16'h10, 1'b0, 1'b0, '0, '0, '0);
        cycle("fetch", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        cycle("idle", 1'b0, 1'b0, '0, 1'b0);

        set_in(1'b1, 16'h30, 1'b1, 1'b0, '0, 16'h50, '0);
        cycle("cont1", 1'b0, 1'b1, 32'hDA7A_0050, 1'b1);
        set_in(1'b1, 16'h30, 1'b1, 1'b0, '0, 16'h51, '0);
        cycle("cont2", 1'b1, 1'b0, 32'hC0DE_0030, 1'b1);
        set_in(1'b1, 16'h31, 1'b1, 1'b0, '0, 16'h51, '0);
        cycle("cont3", 1'b0, 1'b1, 32'hDA7A_0051, 1'b1);
        set_in(1'b1, 16'h31, 1'b1, 1'b0, '0, 16'h52, '0);
        cycle("cont4", 1'b1, 1'b0, 32'hC0DE_0031, 1'b1);
        set_in(1'b1, 16'h32, 1'b1, 1'b0, '0, 16'h52, '0);
        cycle("cont5", 1'b0, 1'b1, 32'hDA7A_0052, 1'b1);
        set_in(1'b1, 16'h32, 1'b1, 1'b0, '0, 16'h53, '0);
        cycle("cont6", 1'b1, 1'b0, 32'hC0DE_0032, 1'b1);

        set_in(1'b0, '0, 1'b1, 1'b1, 4'b0101, 16'h20, 32'h1122_3344);
        #1;
        chk("bw ram_en", {31'b0, ram_en}, 32'd1);
        chk("bw ram_we", {28'b0, ram_we}, 32'h5);
        chk("bw ram_addr", {16'b0, ram_addr}, 32'h20);
        chk("bw ram_wdata", ram_wdata, 32'h1122_3344);
        cycle("bw write", 1'b0, 1'b1, '0, 1'b0);
        set_in(1'b0, '0, 1'b1, 1'b0, 4'hF, 16'h20, '0);
        #1;
        chk("rd ram_we", {28'b0, ram_we}, 32'h0);
        cycle("bw read", 1'b0, 1'b1, 32'hAA22_CC44, 1'b1);

        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, AW'(k), 1'b0, 1'b0, '0, '0, '0);
            cycle("b2b fetch", 1'b1, 1'b0, 32'h0000_1000 + DW'(k), 1'b1);
        end

        set_in(1'b0, '0, 1'b1, 1'b1, 4'b0000, 16'h21, 32'hFFFF_FFFF);
        cycle("zero-strobe write", 1'b0, 1'b1, '0, 1'b0);
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 16'h21, '0);
        cycle("zero-strobe read", 1'b0, 1'b1, 32'h5566_7788, 1'b1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        cycle("idle", 1'b0, 1'b0, '0, 1'b0);

        set_in(1'b1, 16'h02, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("midrst grant", {31'b0, inst_addr_ok}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        set_in(1'b1, 16'h03, 1'b1, 1'b0, '0, 16'h40, '0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle("resume D", 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);
        set_in(1'b1, 16'h03, 1'b0, 1'b0, '0, '0, '0);
        cycle("resume I", 1'b1, 1'b0, 32'h0000_1003, 1'b1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        cycle("idle", 1'b0, 1'b0, '0, 1'b0);
        cycle("idle", 1'b0, 1'b0, '0, 1'b0);

        chk("outstanding responses", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
